// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch/execute sequencer: word width, FSM state
// encodings and the memory-port source selection used by the port mux.
package fetch_sequencer_pkg;

  localparam int WORD_SIZE = 16;

  typedef enum logic [1:0] {
    FS_FETCH  = 2'd0,
    FS_EXEC   = 2'd1,
    FS_HALTED = 2'd2
  } fs_state_t;

  // Which agent owns the shared memory port in the current cycle.
  typedef enum logic [1:0] {
    PORT_IDLE       = 2'd0,
    PORT_FETCH      = 2'd1,
    PORT_DATA_READ  = 2'd2,
    PORT_DATA_WRITE = 2'd3
  } port_sel_t;

  // Data-phase arbitration: a store beats a load when data_path raises both,
  // so a conflicting read is never placed on the bus.
  function automatic port_sel_t data_phase_sel(input logic dp_rd, input logic dp_wr);
    port_sel_t sel;
    if (dp_wr) begin
      sel = PORT_DATA_WRITE;
    end else if (dp_rd) begin
      sel = PORT_DATA_READ;
    end else begin
      sel = PORT_IDLE;
    end
    return sel;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle of the memory-bus and data_path-facing signals of the sequencer.
// master = the sequencer itself, slave = memory bus plus data_path.
interface fetch_sequencer_if #(
  parameter int WORD_SIZE = fetch_sequencer_pkg::WORD_SIZE
);

  // shared memory port
  logic                 readM;
  logic                 writeM;
  logic [WORD_SIZE-1:0] address;
  logic [WORD_SIZE-1:0] outputData;
  logic [WORD_SIZE-1:0] inputData;
  logic                 inputReady;
  logic                 ackOutput;

  // data_path data-phase requests and forwarded completions
  logic                 dp_readM;
  logic                 dp_writeM;
  logic [WORD_SIZE-1:0] dp_address;
  logic [WORD_SIZE-1:0] dp_outputData;
  logic                 dp_inputReady;
  logic                 dp_ackOutput;

  // instruction / PC exchange with data_path
  logic [WORD_SIZE-1:0] instruction;
  logic [WORD_SIZE-1:0] PC;
  logic [WORD_SIZE-1:0] nextPC;
  logic                 halt;
  logic                 commit;
  logic [WORD_SIZE-1:0] num_inst;

  modport master (
    output readM, writeM, address, outputData,
    input  inputData, inputReady, ackOutput,
    input  dp_readM, dp_writeM, dp_address, dp_outputData,
    output dp_inputReady, dp_ackOutput,
    output instruction, PC, commit, num_inst,
    input  nextPC, halt
  );

  modport slave (
    input  readM, writeM, address, outputData,
    output inputData, inputReady, ackOutput,
    output dp_readM, dp_writeM, dp_address, dp_outputData,
    input  dp_inputReady, dp_ackOutput,
    input  instruction, PC, commit, num_inst,
    output nextPC, halt
  );

endinterface

// File: rtl/fetch_sequencer_mem_port_mux.sv
// Combinational steering of the single memory port between the instruction
// fetch and the data_path load/store of the executing instruction.
module mem_port_mux #(
  parameter int WORD_SIZE = fetch_sequencer_pkg::WORD_SIZE
) (
  input  fetch_sequencer_pkg::port_sel_t sel,
  input  logic [WORD_SIZE-1:0]           pc,
  input  logic [WORD_SIZE-1:0]           dp_address,
  input  logic [WORD_SIZE-1:0]           dp_output_data,
  output logic                           read_req,
  output logic                           write_req,
  output logic [WORD_SIZE-1:0]           address,
  output logic [WORD_SIZE-1:0]           output_data
);
  import fetch_sequencer_pkg::*;

  // Idle parks the address on PC with zero write data so the bus is quiet
  // during reset and HALTED.
  always_comb begin
    read_req    = 1'b0;
    write_req   = 1'b0;
    address     = pc;
    output_data = '0;
    case (sel)
      PORT_FETCH: begin
        read_req = 1'b1;
        address  = pc;
      end
      PORT_DATA_READ: begin
        read_req = 1'b1;
        address  = dp_address;
      end
      PORT_DATA_WRITE: begin
        write_req   = 1'b1;
        address     = dp_address;
        output_data = dp_output_data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/execute sequencer. Owns PC, fetches each instruction over
// the shared memory port, holds it while data_path executes, forwards the
// data-phase access and emits a one-cycle commit strobe on retirement.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// FS_FETCH  | read at PC outstanding; inputReady latches the instruction
// FS_EXEC   | instruction/PC held; data_path load/store (if any) on port
// FS_HALTED | HLT retired; port quiet, PC frozen until reset
//
// reset_n is active-high despite its name: 1 holds the block in reset.
module fetch_sequencer #(
  parameter int                   WORD_SIZE = fetch_sequencer_pkg::WORD_SIZE,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input logic                clk,
  input logic                reset_n,
  fetch_sequencer_if.master  bus
);
  import fetch_sequencer_pkg::*;

  fs_state_t            state;
  fs_state_t            state_nxt;
  port_sel_t            port_sel;
  logic                 exec_done;
  logic                 commit_c;
  logic                 load_instr;
  logic                 dp_ready_c;
  logic                 dp_ack_c;
  logic [WORD_SIZE-1:0] pc_q;
  logic [WORD_SIZE-1:0] instr_q;
  logic [WORD_SIZE-1:0] num_inst_q;
  logic                 mux_read;
  logic                 mux_write;
  logic [WORD_SIZE-1:0] mux_address;
  logic [WORD_SIZE-1:0] mux_output_data;

  // Completion of the execute stage: store waits for ack, load for data,
  // an instruction without a data access finishes immediately.
  always_comb begin
    case (data_phase_sel(bus.dp_readM, bus.dp_writeM))
      PORT_DATA_WRITE: exec_done = bus.ackOutput;
      PORT_DATA_READ:  exec_done = bus.inputReady;
      default:         exec_done = 1'b1;
    endcase
  end

  // State register; reset always restarts with a fetch at RESET_PC.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state <= FS_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decision.
  always_comb begin
    state_nxt = state;
    case (state)
      FS_FETCH: begin
        if (bus.inputReady) begin
          state_nxt = FS_EXEC;
        end
      end
      FS_EXEC: begin
        if (exec_done) begin
          state_nxt = bus.halt ? FS_HALTED : FS_FETCH;
        end
      end
      FS_HALTED: state_nxt = FS_HALTED;
      default:   state_nxt = FS_FETCH;
    endcase
  end

  // Per-state outputs; everything is forced quiet while reset is asserted so
  // an access aborted by reset drops its request in the same cycle.
  always_comb begin
    port_sel   = PORT_IDLE;
    commit_c   = 1'b0;
    load_instr = 1'b0;
    dp_ready_c = 1'b0;
    dp_ack_c   = 1'b0;
    if (!reset_n) begin
      case (state)
        FS_FETCH: begin
          port_sel   = PORT_FETCH;
          load_instr = bus.inputReady;
        end
        FS_EXEC: begin
          port_sel   = data_phase_sel(bus.dp_readM, bus.dp_writeM);
          commit_c   = exec_done;
          dp_ready_c = bus.inputReady;
          dp_ack_c   = bus.ackOutput;
        end
        default: ;
      endcase
    end
  end

  // Architectural registers: instruction latch, PC and retire counter.
  // nextPC is taken verbatim; num_inst wraps naturally at the word width.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      num_inst_q <= '0;
    end else begin
      if (load_instr) begin
        instr_q <= bus.inputData;
      end
      if (commit_c) begin
        pc_q       <= bus.nextPC;
        num_inst_q <= num_inst_q + WORD_SIZE'(1);
      end
    end
  end

  mem_port_mux #(
    .WORD_SIZE (WORD_SIZE)
  ) u_mem_port_mux (
    .sel            (port_sel),
    .pc             (pc_q),
    .dp_address     (bus.dp_address),
    .dp_output_data (bus.dp_outputData),
    .read_req       (mux_read),
    .write_req      (mux_write),
    .address        (mux_address),
    .output_data    (mux_output_data)
  );

  assign bus.readM         = mux_read;
  assign bus.writeM        = mux_write;
  assign bus.address       = mux_address;
  assign bus.outputData    = mux_output_data;
  assign bus.dp_inputReady = dp_ready_c;
  assign bus.dp_ackOutput  = dp_ack_c;
  assign bus.instruction   = instr_q;
  assign bus.PC            = pc_q;
  assign bus.commit        = commit_c;
  assign bus.num_inst      = num_inst_q;

endmodule
